// File: rtl/pwm_seq_ctrl.sv
// Purpose : duty-cycle sequencer/arbiter with internal period counter; drives the pwm pin.
// Latency : target updates 1 clk after a command handshake; duty changes only on the period wrap.
// Backpr. : cmd_ready drops for the whole override (EVT_WAIT/EVT); evt_req is level-sampled, never queued.
//
// Ports:
//   clk, rst                      clock, synchronous active-high reset
//   cmd_valid/cmd_byte/cmd_ready  ASCII command byte handshake
//   evt_req/evt_duty/evt_hold     override request (level), duty, length in periods
//   evt_ack                       one-clock pulse when an override is accepted
//   duty                          duty currently applied to the pwm comparator
//   period_end                    high in the last clock of every period
//   busy                          high whenever the sequencer is not IDLE
//   pwm                           registered PWM output
//
// Build option: define PWM_SOFTSTART_EN to ramp duty by at most STEP per period.
// Without it the duty jumps straight to target at the next period boundary.
// STEP must not exceed PERIOD.

module pwm_seq_ctrl #(
    parameter int unsigned PERIOD = 50_000,
    parameter int unsigned STEP   = 500,
    parameter int unsigned CW     = 28
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          cmd_valid,
    input  logic [7:0]    cmd_byte,
    output logic          cmd_ready,
    input  logic          evt_req,
    input  logic [CW-1:0] evt_duty,
    input  logic [7:0]    evt_hold,
    output logic          evt_ack,
    output logic [CW-1:0] duty,
    output logic          period_end,
    output logic          busy,
    output logic          pwm
);

    localparam logic [CW-1:0] PER_C    = CW'(PERIOD);
    localparam logic [CW-1:0] PER_LAST = CW'(PERIOD - 1);
    localparam logic [CW-1:0] STEP_C   = CW'(STEP);
    localparam logic [CW-1:0] MID_C    = CW'((PERIOD * 2) / 5);
    localparam logic [CW-1:0] ONE_C    = CW'(1);

    localparam logic [7:0] CMD_ZERO = 8'h30;  // '0'
    localparam logic [7:0] CMD_MID  = 8'h63;  // 'c'
    localparam logic [7:0] CMD_FULL = 8'h78;  // 'x'
    localparam logic [7:0] CMD_INC  = 8'h2B;  // '+'
    localparam logic [7:0] CMD_DEC  = 8'h2D;  // '-'

    typedef enum logic [1:0] {
        S_IDLE,
        S_RAMP,
        S_EVT_WAIT,
        S_EVT
    } state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [CW-1:0] duty_q, duty_d;
    logic [CW-1:0] target_q, target_d;
    logic [CW-1:0] evt_duty_q, evt_duty_d;
    logic [7:0]    hold_q, hold_d;
    logic          evt_ack_q, evt_ack_d;
    logic          pwm_q, pwm_d;

    logic          wrap;
    logic          arb_open;
    logic          cmd_fire;
    logic [CW-1:0] evt_clamped;
    logic [7:0]    hold_eff;
    logic [CW-1:0] ramp_nxt;

    // ------------------------------------------------------------------
    // Period counter: the wrap clock is the only place duty may change.
    // ------------------------------------------------------------------
    assign wrap  = (cnt_q == PER_LAST);
    assign cnt_d = wrap ? '0 : cnt_q + ONE_C;

    // Commands and overrides are both only taken outside the override.
    assign arb_open = (state_q == S_IDLE) || (state_q == S_RAMP);
    assign cmd_fire = cmd_valid && arb_open;

    assign evt_clamped = (evt_duty > PER_C) ? PER_C : evt_duty;
    assign hold_eff    = (evt_hold == 8'd0) ? 8'd1 : evt_hold;

    // ------------------------------------------------------------------
    // Duty value to apply at the next boundary while heading to target.
    // Always computed from the currently applied duty, so a target change
    // mid-ramp simply redirects from wherever the duty is now.
    // ------------------------------------------------------------------
`ifdef PWM_SOFTSTART_EN
    logic          ramp_up;
    logic [CW-1:0] ramp_diff;

    assign ramp_up   = (target_q > duty_q);
    assign ramp_diff = ramp_up ? (target_q - duty_q) : (duty_q - target_q);

    always_comb begin
        ramp_nxt = target_q;
        if (ramp_diff > STEP_C) begin
            ramp_nxt = ramp_up ? (duty_q + STEP_C) : (duty_q - STEP_C);
        end
    end
`else
    assign ramp_nxt = target_q;
`endif

    // ------------------------------------------------------------------
    // Command decode: saturating +/- on target, unknown bytes swallowed.
    // ------------------------------------------------------------------
    always_comb begin
        target_d = target_q;
        if (cmd_fire) begin
            case (cmd_byte)
                CMD_ZERO: target_d = '0;
                CMD_MID:  target_d = MID_C;
                CMD_FULL: target_d = PER_C;
                CMD_INC:  target_d = (target_q > (PER_C - STEP_C)) ? PER_C : (target_q + STEP_C);
                CMD_DEC:  target_d = (target_q < STEP_C) ? '0 : (target_q - STEP_C);
                default:  target_d = target_q;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Sequencer FSM. An override request wins over a pending ramp step
    // in the same clock; the step is simply retried after the override.
    // ------------------------------------------------------------------
    always_comb begin
        state_d    = state_q;
        duty_d     = duty_q;
        evt_duty_d = evt_duty_q;
        hold_d     = hold_q;
        evt_ack_d  = 1'b0;

        case (state_q)
            S_IDLE, S_RAMP: begin
                if (evt_req) begin
                    evt_duty_d = evt_clamped;
                    hold_d     = hold_eff;
                    evt_ack_d  = 1'b1;
                    state_d    = S_EVT_WAIT;
                end else if (wrap && (duty_q != target_q)) begin
                    duty_d  = ramp_nxt;
                    state_d = (ramp_nxt == target_q) ? S_IDLE : S_RAMP;
                end else begin
                    // Target may have moved since the last boundary.
                    state_d = (duty_q == target_q) ? S_IDLE : S_RAMP;
                end
            end

            S_EVT_WAIT: begin
                if (wrap) begin
                    duty_d  = evt_duty_q;
                    state_d = S_EVT;
                end
            end

            S_EVT: begin
                if (wrap) begin
                    if (hold_q == 8'd1) begin
                        // Last override period ends: the first ramp step
                        // (or the jump to target) lands on this same wrap.
                        duty_d  = ramp_nxt;
                        state_d = (ramp_nxt == target_q) ? S_IDLE : S_RAMP;
                    end else begin
                        hold_d = hold_q - 8'd1;
                    end
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Registered compare on next-state values keeps pwm aligned with the
    // cnt/duty pair of the same clock, so a new duty never splits a period.
    assign pwm_d = (cnt_d < duty_d);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            duty_q     <= '0;
            target_q   <= '0;
            evt_duty_q <= '0;
            hold_q     <= 8'd0;
            evt_ack_q  <= 1'b0;
            pwm_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            duty_q     <= duty_d;
            target_q   <= target_d;
            evt_duty_q <= evt_duty_d;
            hold_q     <= hold_d;
            evt_ack_q  <= evt_ack_d;
            pwm_q      <= pwm_d;
        end
    end

    assign cmd_ready  = arb_open;
    assign evt_ack    = evt_ack_q;
    assign duty       = duty_q;
    assign period_end = wrap;
    assign busy       = (state_q != S_IDLE);
    assign pwm        = pwm_q;

endmodule

// File: tb/tb_pwm_seq_ctrl.sv
// Purpose : self-checking bench for pwm_seq_ctrl with PERIOD=100, STEP=10.
// Latency : expected duty per boundary is queued at stimulus time and popped on each wrap.
// Backpr. : commands are held valid until cmd_ready; stall length is checked during overrides.

module tb_pwm_seq_ctrl;

    localparam int PERIOD = 100;
    localparam int STEP   = 10;
    localparam int CW     = 28;

    logic          clk;
    logic          rst;
    logic          cmd_valid;
    logic [7:0]    cmd_byte;
    logic          cmd_ready;
    logic          evt_req;
    logic [CW-1:0] evt_duty;
    logic [7:0]    evt_hold;
    logic          evt_ack;
    logic [CW-1:0] duty;
    logic          period_end;
    logic          busy;
    logic          pwm;

    pwm_seq_ctrl #(
        .PERIOD (PERIOD),
        .STEP   (STEP),
        .CW     (CW)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .cmd_valid  (cmd_valid),
        .cmd_byte   (cmd_byte),
        .cmd_ready  (cmd_ready),
        .evt_req    (evt_req),
        .evt_duty   (evt_duty),
        .evt_hold   (evt_hold),
        .evt_ack    (evt_ack),
        .duty       (duty),
        .period_end (period_end),
        .busy       (busy),
        .pwm        (pwm)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Scoreboard: one entry per boundary at which duty is expected to change.
    int exp_q[$];
    int exp_tail   = 0;   // duty once the queue drains
    int exp_target = 0;   // model of the internal target
    int cur_exp    = 0;   // duty expected in the current period
    int tb_cnt     = 0;   // bench-owned period counter
    bit mon_en     = 1'b0;
    logic rst_s;

    always @(posedge clk) rst_s <= rst;

    always @(negedge clk) begin
        if (rst_s) begin
            tb_cnt  = 0;
            cur_exp = 0;
            mon_en  = 1'b1;
        end else if (mon_en) begin
            tb_cnt = (tb_cnt == PERIOD - 1) ? 0 : tb_cnt + 1;
            if (tb_cnt == 0 && exp_q.size() != 0) cur_exp = exp_q.pop_front();
        end
        if (mon_en) begin
            check_eq("duty", duty, cur_exp);
            check_eq("pwm", pwm, tb_cnt < cur_exp);
            check_eq("period_end", period_end, tb_cnt == PERIOD - 1);
        end
    end

    function automatic int next_target(input int t, input logic [7:0] b);
        case (b)
            8'h30:   return 0;
            8'h63:   return PERIOD * 2 / 5;
            8'h78:   return PERIOD;
            8'h2B:   return (t + STEP > PERIOD) ? PERIOD : t + STEP;
            8'h2D:   return (t < STEP) ? 0 : t - STEP;
            default: return t;
        endcase
    endfunction

    task automatic push_ramp(input int from, input int to);
        int d;
        d = from;
`ifdef PWM_SOFTSTART_EN
        while (d != to) begin
            if (to > d) d = (to - d > STEP) ? d + STEP : to;
            else        d = (d - to > STEP) ? d - STEP : to;
            exp_q.push_back(d);
        end
`else
        if (d != to) exp_q.push_back(to);
`endif
        exp_tail = to;
    endtask

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    // Park just after a wrap so handshakes never straddle a boundary.
    task automatic to_wrap();
        do tick(); while (tb_cnt != 2);
    endtask

    task automatic send_cmd(input logic [7:0] b, output int stalls);
        cmd_valid = 1'b1;
        cmd_byte  = b;
        stalls    = 0;
        while (!cmd_ready && stalls < 4 * PERIOD) begin
            tick();
            stalls++;
        end
        check_eq("cmd_ready_at_accept", cmd_ready, 1);
        tick();
        cmd_valid  = 1'b0;
        exp_target = next_target(exp_target, b);
    endtask

    task automatic cmd(input logic [7:0] b);
        int s;
        to_wrap();
        send_cmd(b, s);
        push_ramp(exp_tail, exp_target);
    endtask

    task automatic settle();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 30 * PERIOD) begin
            tick();
            n++;
        end
        check_eq("settle_timeout", exp_q.size(), 0);
        tick();
        tick();
        check_eq("busy_idle", busy, 0);
        check_eq("duty_final", duty, exp_tail);
    endtask

    task automatic check_reset_vals(input string tag);
        check_eq({tag, "_duty"}, duty, 0);
        check_eq({tag, "_pwm"}, pwm, 0);
        check_eq({tag, "_busy"}, busy, 0);
        check_eq({tag, "_cmd_ready"}, cmd_ready, 1);
        check_eq({tag, "_evt_ack"}, evt_ack, 0);
        check_eq({tag, "_period_end"}, period_end, 0);
    endtask

    initial begin
        #600_000;
        $display("FAIL watchdog: time limit reached, got running expected finished");
        $fatal(1);
    end

    initial begin
        int stalls;
        int n;

        rst = 1'b1; cmd_valid = 1'b0; cmd_byte = 8'h00;
        evt_req = 1'b0; evt_duty = '0; evt_hold = 8'd0;
        tick(); tick(); tick();
        check_reset_vals("reset");
        rst = 1'b0;

        // Idle: pwm low, nothing moving.
        repeat (300) tick();
        check_eq("idle_busy", busy, 0);
        check_eq("idle_cmd_ready", cmd_ready, 1);

        // Full-scale ramp.
        cmd(8'h78);
        tick();
        check_eq("ramp_busy", busy, 1);
        settle();

        // Override at full duty, 250 clamps to PERIOD, hold 2; a command stalls behind it.
        to_wrap();
        evt_req = 1'b1; evt_duty = CW'(250); evt_hold = 8'd2;
        check_eq("evt_ack_pre", evt_ack, 0);
        tick();
        evt_req = 1'b0;
        check_eq("evt_ack", evt_ack, 1);
        check_eq("evt_cmd_ready", cmd_ready, 0);
        check_eq("evt_busy", busy, 1);
        exp_q.push_back(PERIOD);
        exp_q.push_back(PERIOD);
        push_ramp(PERIOD, exp_target);
        evt_req = 1'b1; evt_duty = CW'(30); evt_hold = 8'd5;
        repeat (3) begin
            tick();
            check_eq("evt_ignored_ack", evt_ack, 0);
        end
        evt_req = 1'b0;
        send_cmd(8'h30, stalls);
        check_eq("cmd_stalled_2_periods", stalls >= 2 * PERIOD, 1);
        push_ramp(exp_tail, exp_target);
        settle();

        // Target arithmetic: 40 -> 30 -> 20 -> 30, then saturation at both ends.
        cmd(8'h63); settle();
        cmd(8'h2D); settle();
        cmd(8'h2D); settle();
        cmd(8'h2B); settle();
        cmd(8'h30); settle();
        cmd(8'h2D); tick(); tick();
        check_eq("dec_sat0_busy", busy, 0);
        cmd(8'h2B); settle();
        cmd(8'h41); tick(); tick();
        check_eq("unknown_byte_busy", busy, 0);
        cmd(8'h78); settle();
        cmd(8'h2B); tick(); tick();
        check_eq("inc_satmax_busy", busy, 0);
        cmd(8'h2D); settle();
        cmd(8'h78); settle();

        // Simultaneous command 0x30 and override 50 with hold 0 (treated as 1).
        to_wrap();
        cmd_valid = 1'b1; cmd_byte = 8'h30;
        evt_req = 1'b1; evt_duty = CW'(50); evt_hold = 8'd0;
        check_eq("simul_cmd_ready", cmd_ready, 1);
        tick();
        cmd_valid = 1'b0; evt_req = 1'b0;
        exp_target = 0;
        check_eq("simul_evt_ack", evt_ack, 1);
        check_eq("simul_cmd_ready_low", cmd_ready, 0);
        exp_q.push_back(50);
        push_ramp(50, exp_target);
        settle();

        // Reset in the middle of a ramp toward full scale.
        cmd(8'h78);
`ifdef PWM_SOFTSTART_EN
        n = 0;
        while (cur_exp != 60 && n < 20 * PERIOD) begin
            tick();
            n++;
        end
        check_eq("reached_60", cur_exp, 60);
        repeat (10) tick();
`else
        tick();
`endif
        check_eq("midramp_busy", busy, 1);
        rst = 1'b1;
        exp_q.delete();
        exp_target = 0;
        exp_tail   = 0;
        tick();
        rst = 1'b0;
        check_reset_vals("midramp_rst");
        repeat (PERIOD + PERIOD / 2) tick();

        // Reset while an override is latched: it must not reappear.
        to_wrap();
        evt_req = 1'b1; evt_duty = CW'(70); evt_hold = 8'd3;
        tick();
        evt_req = 1'b0;
        check_eq("pre_rst_evt_ack", evt_ack, 1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check_reset_vals("evt_rst");
        repeat (2 * PERIOD + 10) tick();
        check_eq("evt_discarded_busy", busy, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/pwm_seq_ctrl.md
# pwm_seq_ctrl

Duty-cycle sequencer and arbiter for the paddle/ball PWM output. It takes ASCII command bytes from the UART receiver and timed override requests from game logic. It ramps the applied duty toward a commanded target and switches duty only at PWM period boundaries, so output pulses never glitch. It contains its own period counter and drives the `pwm` pin directly.

## Interface
- PERIOD, 50_000, clocks per PWM period (one period = 1 kHz at 50 MHz).
- STEP, 500, maximum duty change per period while ramping.
- CW, 28, width of the counter and duty values.
- clk  in  1  system clock.
- rst  in  1  reset: synchronous, active-high.
- cmd_valid  in  1  command byte valid.
- cmd_byte  in  8  ASCII command.
- cmd_ready  out  1  command accepted when cmd_valid && cmd_ready.
- evt_req  in  1  game-logic override request (level).
- evt_duty  in  CW  override duty; values above PERIOD clamp to PERIOD.
- evt_hold  in  8  override length in whole periods; 0 is treated as 1.
- evt_ack  out  1  one-cycle pulse when an override is accepted.
- duty  out  CW  duty currently applied.
- period_end  out  1  one-cycle pulse in the last clock of each period.
- busy  out  1  high while state is not IDLE.
- pwm  out  1  PWM output.

## Operation
- Period counter `cnt` runs 0..PERIOD-1 and then wraps to 0. `period_end` = (cnt == PERIOD-1).
- `pwm` = (cnt < duty), registered.
  - Duty 0 gives constant low.
  - Duty PERIOD gives constant high.
- Command decode. Each accepted byte updates `target` on the next clock:
  - 0x30 sets target to 0.
  - 0x63 sets target to PERIOD*2/5.
  - 0x78 sets target to PERIOD.
  - 0x2B adds STEP to target, saturating at PERIOD.
  - 0x2D subtracts STEP from target, saturating at 0.
  - Any other byte is accepted and discarded.
- States:
  - IDLE: duty == target.
  - RAMP: duty != target; at each boundary, duty moves toward target by min(STEP, |target-duty|). Returns to IDLE when duty == target.
  - EVT_WAIT: override accepted, waiting for the next boundary.
  - EVT: duty = latched evt_duty; counts evt_hold boundaries, then goes to RAMP, or to IDLE if duty == target.
- Arbitration:
  - evt_req is sampled only in IDLE or RAMP. It has priority over ramping.
  - On acceptance, evt_duty and evt_hold are latched, the state goes to EVT_WAIT, and evt_ack pulses.
  - evt_req is ignored in EVT_WAIT and EVT; it is not queued.
- cmd_ready is 0 in EVT_WAIT and EVT, and 1 otherwise. Commands stall during an override; target is unchanged by the override itself.
- Simultaneous command and evt_req in IDLE/RAMP: both are accepted. Target updates and the override starts.

## Timing
- Reset values:
  - cnt=0, duty=0, target=0, state IDLE.
  - pwm=0, cmd_ready=1, evt_ack=0, busy=0, period_end=0.
- Command handshake completes in the cycle where valid && ready are both high. Target is updated one cycle later.
- duty changes only on the clock where cnt wraps PERIOD-1→0. The first period after a change uses the new duty.
- evt_req sampled high at cycle t gives evt_ack high at t+1. The override duty applies from the next wrap after t.
- After EVT ends, the ramp starts at the following boundary.
- A target change mid-ramp redirects the ramp at the next boundary; there is no restart.
- rst mid-override or mid-ramp returns everything to reset values on the next clock. The latched event is discarded.

## Configuration
- PWM_SOFTSTART_EN defined: RAMP behaves as above.
- PWM_SOFTSTART_EN undefined:
  - STEP is ignored for ramping; duty jumps to target at the next boundary and RAMP lasts at most one period.
  - After EVT, duty returns to target at the next boundary.
  - STEP still sets the 0x2B/0x2D increment.

## Test plan
Bench parameters: PERIOD=100, STEP=10.

- Reset, then idle 300 cycles → pwm stays 0, duty=0, busy=0, cmd_ready=1.
- Send 0x78 (soft-start enabled) → target=100; duty goes 10, 20, …, 100 at successive wraps; busy falls after the 10th wrap; pwm is then constant high.
- From duty=40, send 0x2D twice, then 0x2B; also send 0x2D at target 0 → target goes 30, 20, 30; the saturating case holds target at 0.
- At duty=100, assert evt_req with evt_duty=250, evt_hold=2 → evt_ack pulses the next cycle; duty=100 (clamped) for 2 periods; cmd_ready=0 throughout; a command presented during this time stalls until the override ends.
- In the same cycle, send cmd 0x30 and assert evt_req with evt_duty=50, evt_hold=0 → both accepted; duty=50 for 1 period; then ramps 40, 30, …, 0.
- Mid-ramp at duty=60 toward 100, assert rst → the next clock shows all reset values; pwm=0 for the next full period.
